imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator that sits between instruction fetch/decode and the register-read stage. Decodes the opcode from the instruction word itself and produces the correctly sign-extended immediate for all base formats (I, S, B, U, J) plus a format tag. Fully registered output behind a 2-entry valid/ready skid buffer, so the stage sustains one instruction per cycle under downstream backpressure.

## Interface
- `XLEN`, default 64: data width; legal values 32 and 64.
- `FMT_W`, default 3: width of the format tag.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; discards all buffered entries.
- `in_valid` input 1: `in_inst` is valid.
- `in_ready` output 1: block accepts `in_inst` this cycle.
- `in_inst` input 32: raw instruction word.
- `out_valid` output 1: `out_imm` and `out_fmt` are valid.
- `out_ready` input 1: consumer accepts the output this cycle.
- `out_imm` output XLEN: sign-extended immediate.
- `out_fmt` output FMT_W: format tag; 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_illegal` output 1: present only with `IMM_GEN_ILLEGAL_EN` defined.
- `illegal_cnt` output 16: present only with `IMM_GEN_ILLEGAL_EN` defined.

## Operation
- Opcode is `in_inst[6:0]`. Decode map:
  - U: 0110111 (LUI), 0010111 (AUIPC).
  - J: 1101111.
  - I: 1100111, 0000011, 0010011; also 0011011, but only when XLEN=64.
  - B: 1100011.
  - S: 0100011.
  - Any other opcode: NONE, with imm 0.
- Immediate construction, each result sign-extended from bit 31 of the instruction to XLEN:
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U: `{inst[31:12], 12'b0}`.
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- Shift-immediate forms use the I-format immediate unchanged; shamt extraction belongs to the ALU.
- Decode is combinational on the input side. The result is written into a main register; a skid register captures one further entry while the output is stalled.
- State machine:
  - EMPTY: `out_valid`=0.
  - ONE: main register valid, skid empty.
  - FULL: both registers valid.
- Transitions, where accept = `in_valid & in_ready` and drain = `out_valid & out_ready`:
  - EMPTY: accept goes to ONE.
  - ONE: accept without drain goes to FULL; drain without accept goes to EMPTY; both together stay in ONE, with main loaded from the new input.
  - FULL: drain goes to ONE, with skid moving to main.
- `in_ready` is registered and equals (state != FULL). No combinational path from `out_ready` to `in_ready`.
- `flush` goes to EMPTY next cycle and overrides any accept in the same cycle; the flushed-cycle input is dropped.
- Output ordering is strict FIFO.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `illegal_cnt`=0, state EMPTY.
- Latency: an input accepted at edge N is presented at `out_valid` after edge N.
- Throughput: 1 per cycle while `out_ready`=1.
- Holding rule: while `out_valid & !out_ready`, `out_imm`, `out_fmt` and `out_illegal` stay stable.
- Reset mid-operation: all entries are lost immediately on `rst_n` falling.
- Flush and `rst_n` both clear state; reset takes priority.

## Configuration
- `IMM_GEN_ILLEGAL_EN` defined:
  - `out_illegal` travels with each entry; it is 1 when the format is NONE or `in_inst[1:0]`!=2'b11.
  - `illegal_cnt` increments on each accepted illegal instruction and saturates at 16'hFFFF.
  - Flush does not clear the counter; only reset does.
- Not defined: both ports and the counter are absent, and NONE entries pass silently with imm 0.

## Test plan
- Reset: assert `rst_n`=0 mid-stream -> `out_valid`=0, `in_ready`=1, `out_imm`=0 immediately; EMPTY after release.
- XLEN=64, inst 32'hFFF00093 (addi -1) -> one cycle later `out_imm`=64'hFFFF_FFFF_FFFF_FFFF, `out_fmt`=1.
- inst 32'hFE000EE3 (beq -4) -> `out_imm`=64'hFFFF_FFFF_FFFF_FFFC, `out_fmt`=3; inst 32'h800002B7 (lui 0x80000) -> `out_imm`=64'hFFFF_FFFF_8000_0000, `out_fmt`=4.
- Backpressure:
  - `out_ready`=0 while driving three valid instructions back-to-back -> first two accepted, `in_ready`=0 the cycle after the second accept, third held.
  - `out_ready`=1 afterwards -> all three emerge in order, one per cycle.
- Flush: buffer FULL, pulse `flush` with `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle input never appears.
- With `IMM_GEN_ILLEGAL_EN`: inst 32'h0000007F -> `out_fmt`=0, `out_imm`=0, `out_illegal`=1, `illegal_cnt` 0->1; an XLEN=32 build given opcode 0011011 also flags illegal.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// Decodes in_inst[6:0] into a format tag and produces the sign-extended
// immediate for the I, S, B, U and J formats. The result is held in a
// two-entry (main + skid) valid/ready buffer, so one instruction per cycle
// can be sustained while downstream backpressure is absorbed.
// Optional build macro: IMM_GEN_ILLEGAL_EN adds the out_illegal flag and a
// saturating illegal-instruction counter (illegal_cnt).
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int FMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
`endif
);

    // Format tag encodings seen by the consumer.
    localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
    localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
    localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
    localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
    localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
    localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);

    // Major opcodes that carry an immediate.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OPIMMW = 7'b0011011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // One buffered result; the illegal flag only exists when it is observable.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [FMT_W-1:0] fmt;
`ifdef IMM_GEN_ILLEGAL_EN
        logic             illegal;
`endif
    } entry_t;

    // Buffer occupancy: main register only, or main plus skid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    entry_t      dec;
    logic [31:0] imm32;
    logic        accept;
    logic        drain;

    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;
    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    assign out_illegal = main_q.illegal;
`endif

    // Decode the incoming instruction into a 32-bit immediate and format tag.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; a missing default here would infer a latch.
        imm32   = 32'd0;
        dec.fmt = FMT_NONE;
        unique case (in_inst[6:0])
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                imm32   = {in_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_OPIMMW: begin
                // The word-sized ALU ops only exist on RV64.
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            default: begin
                dec.fmt = FMT_NONE;
                imm32   = 32'd0;
            end
        endcase
        // Every format is already sign-extended to 32 bits; widen to XLEN.
        dec.imm = XLEN'($signed(imm32));
`ifdef IMM_GEN_ILLEGAL_EN
        dec.illegal = (dec.fmt == FMT_NONE) || (in_inst[1:0] != 2'b11);
`endif
    end

    // Next occupancy and register contents from accept/drain/flush.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // The input offered in a flush cycle is dropped, not accepted.
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = dec;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        main_d = dec;
                    end else if (accept) begin
                        state_d = S_FULL;
                        skid_d  = dec;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (drain) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
        // Registered ready: depends only on the next state, never on out_ready.
        in_ready_d = (state_d != S_FULL);
    end

    // State, ready and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            // NOTE: the data registers are reset too, because out_imm and
            // out_fmt must read zero while reset is held.
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef IMM_GEN_ILLEGAL_EN
    logic [15:0] illegal_cnt_q;
    logic        count_illegal;

    assign count_illegal = accept & ~flush & dec.illegal;
    assign illegal_cnt   = illegal_cnt_q;

    // Saturating count of accepted illegal instructions; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= 16'd0;
        end else if (count_illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an XLEN=64 and an XLEN=32 instance share the
// same stimulus; a queue-based reference model predicts both.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
`ifdef IMM_GEN_ILLEGAL_EN
    logic        out_ill64, out_ill32;
    logic [15:0] cnt64, cnt32;
`endif

    imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(out_ill64), .illegal_cnt(cnt64)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .FMT_W(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(out_ill32), .illegal_cnt(cnt32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm64;
        logic [63:0] imm32;
        int          fmt64;
        int          fmt32;
        logic        ill64;
        logic        ill32;
    } exp_t;

    exp_t q[$];
    int   model_cnt64;
    int   model_cnt32;
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Immediate rules by arithmetic: sign parts come from an arithmetic
    // shift of the whole word, remaining fields are weighted by position.
    function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                    output logic [63:0] imm, output int fmt,
                                    output logic ill);
        longint s;
        longint v;
        s   = longint'($signed(i));
        v   = 0;
        fmt = 0;
        case (i[6:0])
            7'h37, 7'h17: begin
                fmt = 4;
                v   = longint'($signed(i & 32'hFFFF_F000));
            end
            7'h6F: begin
                fmt = 5;
                v   = (s >>> 31) * 64'sd1048576 + longint'(i[19:12]) * 4096
                    + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h13: begin
                fmt = 1;
                v   = s >>> 20;
            end
            7'h1B: begin
                if (xlen == 64) begin
                    fmt = 1;
                    v   = s >>> 20;
                end
            end
            7'h63: begin
                fmt = 3;
                v   = (s >>> 31) * 4096 + longint'(i[7]) * 2048
                    + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            end
            7'h23: begin
                fmt = 2;
                v   = (s >>> 25) * 32 + longint'(i[11:7]);
            end
            default: v = 0;
        endcase
        imm = (xlen == 32) ? {32'd0, v[31:0]} : v;
        ill = (fmt == 0) || (i[1:0] != 2'b11);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".in_ready64"}, 64'(in_ready64), 64'(q.size() < 2));
        check({tag, ".out_valid64"}, 64'(out_valid64), 64'(q.size() > 0));
        check({tag, ".in_ready32"}, 64'(in_ready32), 64'(q.size() < 2));
        check({tag, ".out_valid32"}, 64'(out_valid32), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check({tag, ".imm64"}, out_imm64, q[0].imm64);
            check({tag, ".fmt64"}, 64'(out_fmt64), 64'(q[0].fmt64));
            check({tag, ".imm32"}, {32'd0, out_imm32}, q[0].imm32);
            check({tag, ".fmt32"}, 64'(out_fmt32), 64'(q[0].fmt32));
`ifdef IMM_GEN_ILLEGAL_EN
            check({tag, ".ill64"}, 64'(out_ill64), 64'(q[0].ill64));
            check({tag, ".ill32"}, 64'(out_ill32), 64'(q[0].ill32));
`endif
        end
`ifdef IMM_GEN_ILLEGAL_EN
        check({tag, ".cnt64"}, 64'(cnt64), 64'(model_cnt64));
        check({tag, ".cnt32"}, 64'(cnt32), 64'(model_cnt32));
`endif
    endtask

    // Drive one cycle, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic v, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        exp_t e;
        logic acc;
        logic drn;
        in_valid  = v;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        acc = v && (q.size() < 2);
        drn = rdy && (q.size() > 0);
        ref_dec(inst, 64, e.imm64, e.fmt64, e.ill64);
        ref_dec(inst, 32, e.imm32, e.fmt32, e.ill32);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (e.ill64 && model_cnt64 < 65535) model_cnt64++;
                if (e.ill32 && model_cnt32 < 65535) model_cnt32++;
            end
        end
        #1;
        compare_all(tag);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h63, 7'h23};
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) r[6:0] = ops[k];
        return r;
    endfunction

    localparam logic [31:0] I_ADDI = 32'hFFF0_0093;
    localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] I_LUI  = 32'h8000_02B7;

    initial begin
        checks      = 0;
        errors      = 0;
        model_cnt64 = 0;
        model_cnt32 = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_inst     = 32'd0;
        out_ready   = 1'b0;

        // Reset state.
        #12;
        compare_all("reset");
        check("reset.out_imm64", out_imm64, 64'd0);
        check("reset.out_fmt64", 64'(out_fmt64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed immediates.
        step("addi", 1'b1, I_ADDI, 1'b1, 1'b0);
        check("addi.imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi.fmt", 64'(out_fmt64), 64'd1);
        step("beq", 1'b1, I_BEQ, 1'b1, 1'b0);
        check("beq.imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq.fmt", 64'(out_fmt64), 64'd3);
        step("lui", 1'b1, I_LUI, 1'b1, 1'b0);
        check("lui.imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui.fmt", 64'(out_fmt64), 64'd4);
        check("lui.imm32", {32'd0, out_imm32}, 64'h0000_0000_8000_0000);
        step("drain0", 1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: two accepted, third held until space frees.
        step("bp1", 1'b1, I_ADDI, 1'b0, 1'b0);
        step("bp2", 1'b1, I_BEQ, 1'b0, 1'b0);
        check("bp2.in_ready_low", 64'(in_ready64), 64'd0);
        step("bp3", 1'b1, I_LUI, 1'b0, 1'b0);
        check("bp3.hold_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        step("bp4", 1'b1, I_LUI, 1'b1, 1'b0);
        check("bp4.second", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        step("bp5", 1'b1, I_LUI, 1'b1, 1'b0);
        check("bp5.third", out_imm64, 64'hFFFF_FFFF_8000_0000);
        step("bp6", 1'b0, 32'd0, 1'b1, 1'b0);
        check("bp6.empty", 64'(out_valid64), 64'd0);

        // Flush with a full buffer and a valid input in the same cycle.
        step("fl1", 1'b1, I_ADDI, 1'b0, 1'b0);
        step("fl2", 1'b1, I_BEQ, 1'b0, 1'b0);
        step("fl3", 1'b1, I_LUI, 1'b0, 1'b1);
        check("flush.out_valid", 64'(out_valid64), 64'd0);
        check("flush.in_ready", 64'(in_ready64), 64'd1);
        step("fl4", 1'b0, 32'd0, 1'b1, 1'b0);
        check("flush.dropped", 64'(out_valid64), 64'd0);

        // Word-sized op-imm: I format on RV64, NONE on RV32.
        step("addiw", 1'b1, 32'hFFF0_009B, 1'b1, 1'b0);
        check("addiw.fmt64", 64'(out_fmt64), 64'd1);
        check("addiw.fmt32", 64'(out_fmt32), 64'd0);
        check("addiw.imm32", {32'd0, out_imm32}, 64'd0);
        // Unknown opcode passes as NONE with a zero immediate.
        step("none", 1'b1, 32'h0000_007F, 1'b1, 1'b0);
        check("none.fmt", 64'(out_fmt64), 64'd0);
        check("none.imm", out_imm64, 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        check("none.illegal", 64'(out_ill64), 64'd1);
        check("none.cnt64", 64'(cnt64), 64'd1);
        check("addiw.cnt32", 64'(cnt32), 64'd2);
`endif
        step("drain1", 1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic with random backpressure and rare flushes.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 3) != 0), rand_inst(),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end

        // Reset mid-stream: fill, then drop rst_n between edges.
        step("pre_rst1", 1'b1, I_BEQ, 1'b0, 1'b0);
        step("pre_rst2", 1'b1, 32'h0000_007F, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        model_cnt64 = 0;
        model_cnt32 = 0;
        compare_all("midrst");
        check("midrst.out_imm64", out_imm64, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 32'd0, 1'b1, 1'b0);
        step("post_rst_acc", 1'b1, I_ADDI, 1'b1, 1'b0);
        check("post_rst.imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
